// File: rtl/truth_table_sweep_pkg.sv
// Shared encodings and sizes for the truth-table sweep block.
// Compile-time option: SWEEP_SETTLE_EN (adds a settle cycle before each sample).
package truth_table_sweep_pkg;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/truth_table_sweep_row_counter.sv
// Row counter for the sweep: clear has priority, saturates on the last row.
module sweep_row_counter
  import truth_table_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (clr) begin
      row_d = '0;
    end else if (en && !last) begin
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row  = row_q;
  assign last = (row_q == LAST_ROW);

endmodule

// File: rtl/truth_table_sweep.sv
// Sweeps a 3-input function through all 8 rows, builds its minterm mask and compares it.
// Compile-time option: SWEEP_SETTLE_EN (one settle cycle per row before sampling).
//
// state  | meaning
// IDLE   | waiting for start; x/y/z parked at 000
// SETTLE | row driven, function output allowed to settle (SWEEP_SETTLE_EN only)
// RUN    | sample s into mask[row], advance row
// DONE   | one-cycle done pulse, result valid
module truth_table_sweep
  import truth_table_sweep_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       s,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mask
);

  state_e           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             row_clr;
  logic             row_en;
  logic [ROW_W-1:0] row;
  logic             row_last;

  sweep_row_counter u_row (
    .clk   (clk),
    .reset (reset),
    .clr   (row_clr),
    .en    (row_en),
    .row   (row),
    .last  (row_last)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    row_clr = 1'b0;
    row_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef SWEEP_SETTLE_EN
          state_d = ST_SETTLE;
`else
          state_d = ST_RUN;
`endif
          row_clr = 1'b1;
          mask_d  = 8'h00;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
`ifdef SWEEP_SETTLE_EN
      ST_SETTLE: begin
        state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        mask_d[row] = s;
        if (row_last) begin
          // Clearing the counter here parks x/y/z at 000 for DONE and IDLE.
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mask_d == expected);
          row_clr = 1'b1;
        end else begin
          row_en = 1'b1;
`ifdef SWEEP_SETTLE_EN
          state_d = ST_SETTLE;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= 8'h00;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign x    = row[2];
  assign y    = row[1];
  assign z    = row[0];
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench for truth_table_sweep; the function under test is a truth table held in tt_cur.
module tb_truth_table_sweep;

`ifdef SWEEP_SETTLE_EN
  localparam int SPR = 2;
`else
  localparam int SPR = 1;
`endif
  localparam int TOTAL = 8 * SPR;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] expected;
  logic       s;
  logic       x, y, z;
  logic       busy, done, pass;
  logic [7:0] mask;
  logic [7:0] tt_cur;

  int n_checks = 0;
  int n_errors = 0;

  truth_table_sweep dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .expected (expected),
    .s        (s),
    .x        (x),
    .y        (y),
    .z        (z),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .mask     (mask)
  );

  always #5 clk = ~clk;

  assign s = tt_cur[{x, y, z}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep from IDLE; expected is scrambled until the cycle before the final sample.
  task automatic sweep(input logic [7:0] tt, input logic [7:0] exp_final, input bit poke_start);
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    tt_cur   = tt;
    expected = 8'($urandom);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= TOTAL + 1; k++) begin
      if (done === 1'b1) done_seen++;
      if (k < TOTAL) begin
        check("busy_run", busy, 1'b1);
        check("done_run", done, 1'b0);
        check("xyz_run", {x, y, z}, k / SPR);
      end else if (k == TOTAL) begin
        check("done_end", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("mask_end", mask, tt);
        check("pass_end", pass, (tt == exp_final));
        check("xyz_end", {x, y, z}, 3'b000);
      end else begin
        check("done_after", done, 1'b0);
        check("busy_after", busy, 1'b0);
      end
      if (k == TOTAL - 1) expected = exp_final;
      else if (k < TOTAL - 1) expected = 8'($urandom);
      start = (poke_start && (k == 3)) ? 1'b1 : 1'b0;
      if (k <= TOTAL) @(negedge clk);
    end
    start = 1'b0;
    check("done_count", done_seen, 1);
  endtask

  initial begin
    int nd;
    int dt[3];
    logic [7:0] tt_r, exp_r;

    reset    = 1'b1;
    start    = 1'b0;
    expected = 8'h00;
    tt_cur   = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_mask", mask, 8'h00);
    check("rst_xyz", {x, y, z}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    sweep(8'hAA, 8'hAA, 1'b0);
    sweep(8'hAA, 8'hAB, 1'b0);
    sweep(8'hFF, 8'hFF, 1'b0);
    sweep(8'h00, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    check("hold_mask", mask, 8'h00);
    check("hold_pass", pass, 1'b1);
    check("idle_xyz", {x, y, z}, 3'b000);

    sweep(8'hAA, 8'hAA, 1'b1);

    for (int i = 0; i < 4; i++) begin
      tt_r  = 8'($urandom);
      exp_r = ($urandom_range(0, 1) == 1) ? tt_r : (tt_r ^ (8'h01 << $urandom_range(0, 7)));
      sweep(tt_r, exp_r, 1'b0);
    end

    // start held high: back-to-back sweeps with one IDLE cycle between them
    tt_cur   = 8'hAA;
    expected = 8'hAA;
    start    = 1'b1;
    nd       = 0;
    for (int c = 0; c < 3 * (TOTAL + 2); c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) dt[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    check("held_count", nd, 3);
    check("held_first", dt[0], TOTAL);
    check("held_gap1", dt[1] - dt[0], TOTAL + 2);
    check("held_gap2", dt[2] - dt[1], TOTAL + 2);
    repeat (TOTAL + 2) @(negedge clk);
    check("held_pass", pass, 1'b1);
    check("held_busy", busy, 1'b0);

    // reset in the middle of the 4th row
    tt_cur   = 8'h3C;
    expected = 8'h3C;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3 * SPR; k++) @(negedge clk);
    check("mid_xyz", {x, y, z}, 3'b011);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_pass", pass, 1'b0);
    check("mrst_mask", mask, 8'h00);
    check("mrst_xyz", {x, y, z}, 3'b000);
    nd = 0;
    for (int c = 0; c < TOTAL + 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("mrst_nodone", nd, 0);
    check("mrst_idle_xyz", {x, y, z}, 3'b000);
    sweep(8'h3C, 8'h3C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 expected  input  8  expected minterm mask; bit i = f(row i).
REQ-006 s  input  1  output of the 3-input combinational function under test.
REQ-007 x, y, z  output  1 each  drive to the function under test; row index i = {x,y,z}, x is the MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at the end of a sweep.
REQ-010 pass  output  1  registered result: observed mask equals expected; held until the next accepted start.
REQ-011 mask  output  8  observed minterm mask; held until the next accepted start.

Function
REQ-012 The state machine SHALL have states IDLE, RUN, DONE, plus SETTLE when configured; all outputs are registered.
REQ-013 In IDLE with start=1 at edge E0: go to RUN, row=0, clear mask and pass, set busy=1.
REQ-014 In RUN: {x,y,z}=row; at each sample edge, mask[row] <= s and row increments.
REQ-015 Unconfigured timing: s is sampled at edges E1..E8, one row per cycle.
REQ-016 After row 7 is sampled at E8, the state SHALL go to DONE, with done=1, busy=0 and pass=(final mask==expected) in the cycle after E8.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-018 x, y, z SHALL return to 0 in IDLE.
REQ-019 start SHALL be ignored in RUN, SETTLE and DONE; there is no queuing.
REQ-020 expected SHALL be sampled only at the final compare, so it may change during the sweep.
REQ-021 Row 7 SHALL be the last row; the counter SHALL NOT wrap into a second pass.
REQ-022 start held high continuously SHALL produce back-to-back sweeps separated by one IDLE cycle.

Reset
REQ-023 When reset=1 at a clock edge, the block SHALL enter IDLE with row=0, x=y=z=0, busy=0, done=0, pass=0, mask=8'h00.
REQ-024 reset SHALL take priority over start and over every state, including mid-sweep; a partial sweep is discarded with no done pulse.

Configuration
REQ-025 Macro SWEEP_SETTLE_EN SHALL be the only compile-time option.
REQ-026 Defined: each row spends one SETTLE cycle (row driven, no sample), then one RUN cycle that samples.
REQ-027 Defined: sample edges are E2, E4, ..., E16, and done is high in the cycle after E16.
REQ-028 Undefined: the SETTLE state and its logic SHALL be absent, and timing follows REQ-015/016.
REQ-029 All ports are identical in both builds.

Structure
REQ-030 A shared package/header SHALL hold the state encodings (IDLE, SETTLE, RUN, DONE), NUM_ROWS=8 and ROW_W=3.
REQ-031 One sub-module, sweep_row_counter, SHALL hold the 3-bit row counter with clear, enable and last-row flag.
REQ-032 The FSM, mask register and compare SHALL live in the top module.

Verification
REQ-033 Function f=z (minterms 1,3,5,7), expected=8'hAA, start pulse -> mask=8'hAA, pass=1, done high exactly 1 cycle, 8 cycles after acceptance (16 with SWEEP_SETTLE_EN).
REQ-034 Same function, expected=8'hAB -> mask=8'hAA, pass=0, done pulses once.
REQ-035 Constant-1 function, expected=8'hFF -> mask=8'hFF, pass=1; then constant-0 function, expected=8'h00 -> pass=1, mask=8'h00.
REQ-036 reset asserted during the 4th row -> next cycle IDLE with all outputs zero and no done; a new start then yields a full correct sweep.
REQ-037 start pulsed again mid-sweep -> ignored, exactly one done; start held high -> done pulses spaced by sweep length plus 2 cycles.
REQ-038 x,y,z monitored during a sweep -> 000 through 111 in ascending order, each held 1 cycle (2 with SWEEP_SETTLE_EN), and 000 in IDLE.
